// File: rtl/burst_rr_arbiter_pkg.sv
// Shared types and helpers for the burst round-robin arbiter.
// Holds the ownership state encoding and a generic one-hot builder.
package burst_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned MaxOneHotW = 32;

    function automatic logic [MaxOneHotW-1:0] onehot(
        input int unsigned idx,
        input int unsigned n
    );
        logic [MaxOneHotW-1:0] v;
        v = '0;
        if (idx < n && idx < MaxOneHotW) begin
            v[idx[4:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/burst_rr_arbiter_pick.sv
// Circular priority pick: first set request at or after ptr, wrapping.
// Scans a doubled request vector masked to the window [ptr, ptr+NumReq).
module rr_priority_pick #(
    parameter int NumReq = 4,
    parameter int IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              found_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [2*NumReq-1:0] dbl_req;
    logic [2*NumReq-1:0] win;
    logic [2*NumReq-1:0] masked;

    always_comb begin
        dbl_req = {req_i, req_i};
        win     = '0;
        for (int i = 0; i < 2*NumReq; i++) begin
            win[i] = (i >= int'(ptr_i)) && (i < int'(ptr_i) + NumReq);
        end
        masked  = dbl_req & win;
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < 2*NumReq; i++) begin
            if (masked[i] && !found_o) begin
                found_o = 1'b1;
                idx_o   = IdxW'(i % NumReq);
            end
        end
    end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Registered round-robin arbiter holding an owner for up to MaxBurst beats.
// Define BURST_RR_ARBITER_LOCK_EN to add lock_i, which suspends the burst limit.
module burst_rr_arbiter
    import burst_rr_arbiter_pkg::*;
#(
    parameter int  NumReq   = 4,
    parameter int  MaxBurst = 4,
    localparam int IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int CntW     = $clog2(MaxBurst + 1)
) (
    input  logic              clk_i,
    input  logic              arst_ni,
`ifdef BURST_RR_ARBITER_LOCK_EN
    input  logic              lock_i,
`endif
    input  logic              allow_req_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              ack_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              gnt_valid_o,
    output logic [CntW-1:0]   beat_cnt_o
);

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NumReq-1:0] gnt_q, gnt_d;

    logic [IdxW-1:0]   nxt_ptr;
    logic [IdxW-1:0]   pick_idx, rel_idx;
    logic              pick_found, rel_found;
    logic              own_req, beat, at_limit, rel, lock_w;

`ifdef BURST_RR_ARBITER_LOCK_EN
    assign lock_w = lock_i;
`else
    assign lock_w = 1'b0;
`endif

    assign nxt_ptr  = (owner_q == IdxW'(NumReq - 1)) ? '0
                                                     : owner_q + IdxW'(1);
    assign own_req  = req_i[owner_q];
    assign beat     = (state_q == ARB_OWN) && ack_i && own_req;
    assign at_limit = (cnt_q >= CntW'(MaxBurst - 1));
    assign rel      = !own_req || (beat && at_limit && !lock_w);

    rr_priority_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Release pick starts after the owner so it is scanned last.
    rr_priority_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rel_pick (
        .req_i   (req_i),
        .ptr_i   (nxt_ptr),
        .found_o (rel_found),
        .idx_o   (rel_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (allow_req_i && pick_found) begin
                    state_d = ARB_OWN;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_OWN: begin
                if (rel) begin
                    ptr_d = nxt_ptr;
                    cnt_d = '0;
                    if (allow_req_i && rel_found) begin
                        owner_d = rel_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        owner_d = '0;
                    end
                end else if (beat && cnt_q != CntW'(MaxBurst)) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
        gnt_d = (state_d == ARB_OWN)
              ? NumReq'(onehot(32'(owner_d), NumReq))
              : '0;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = owner_q;
    assign gnt_valid_o = |gnt_q;
    assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Self-checking bench for burst_rr_arbiter: directed steps plus random traffic
// compared each cycle against an ownership/priority model.
module tb_burst_rr_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         allow;
    logic         ack;
    logic         lock;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gidx;
    logic         gvalid;
    logic [2:0]   bcnt;

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 when idle), rotating pointer, beat count.
    int m_owner;
    int m_ptr;
    int m_cnt;

    always #5 clk = ~clk;

    burst_rr_arbiter #(
        .NumReq   (N),
        .MaxBurst (MB)
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
`ifdef BURST_RR_ARBITER_LOCK_EN
        .lock_i      (lock),
`endif
        .allow_req_i (allow),
        .req_i       (req),
        .ack_i       (ack),
        .gnt_o       (gnt),
        .gnt_idx_o   (gidx),
        .gnt_valid_o (gvalid),
        .beat_cnt_o  (bcnt)
    );

    function automatic int pick(logic [N-1:0] r, int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        bit own;
        bit bt;
        bit lk;
        int c;
`ifdef BURST_RR_ARBITER_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        if (m_owner < 0) begin
            if (allow && req != '0) begin
                m_owner = pick(req, m_ptr);
                m_cnt   = 0;
            end
        end else begin
            own = req[m_owner];
            bt  = ack && own;
            c   = bt ? m_cnt + 1 : m_cnt;
            if (!own || (bt && c >= MB && !lk)) begin
                m_ptr = (m_owner + 1) % N;
                m_cnt = 0;
                if (allow && req != '0) m_owner = pick(req, m_ptr);
                else m_owner = -1;
            end else begin
                m_cnt = (c > MB) ? MB : c;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), (m_owner < 0) ? 0 : (32'd1 << m_owner));
        chk("gnt_idx", 32'(gidx), (m_owner < 0) ? 0 : m_owner);
        chk("gnt_valid", 32'(gvalid), (m_owner >= 0) ? 1 : 0);
        chk("beat_cnt", 32'(bcnt), m_cnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        arst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(gvalid), 0);
        chk("rst_cnt", 32'(bcnt), 0);
        arst_n = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0;
        req    = 4'b1111;
        allow  = 1'b1;
        ack    = 1'b0;
        lock   = 1'b0;
        model_reset();
        #12;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_idx", 32'(gidx), 0);
        chk("reset_valid", 32'(gvalid), 0);
        chk("reset_cnt", 32'(bcnt), 0);
        arst_n = 1'b1;

        cycle();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_idx", 32'(gidx), 0);

        // burst limit with back-to-back handover
        req = 4'b0101;
        ack = 1'b1;
        repeat (4) cycle();
        chk("burst_to_2", 32'(gnt), 32'h4);
        repeat (4) cycle();
        chk("burst_to_0", 32'(gnt), 32'h1);
        repeat (4) cycle();
        chk("burst_to_2b", 32'(gnt), 32'h4);
        repeat (2) cycle();
        chk("two_beats", 32'(bcnt), 2);

        // early release to pending requester 3
        req = 4'b1000;
        cycle();
        chk("early_gnt", 32'(gnt), 32'h8);
        chk("early_cnt", 32'(bcnt), 0);

        // owner drops, then ack while idle is ignored
        req = 4'b0000;
        repeat (4) cycle();
        chk("idle_cnt", 32'(bcnt), 0);
        chk("idle_valid", 32'(gvalid), 0);

        // allow low mid-burst ends in idle, pointer wraps
        req = 4'b0010;
        ack = 1'b0;
        cycle();
        chk("own1", 32'(gnt), 32'h2);
        ack   = 1'b1;
        allow = 1'b0;
        req   = 4'b0011;
        repeat (4) cycle();
        chk("noallow_idle", 32'(gvalid), 0);
        allow = 1'b1;
        ack   = 1'b0;
        cycle();
        chk("wrap_gnt", 32'(gnt), 32'h1);

        // reset mid-burst drops the grant at once
        ack = 1'b1;
        cycle();
        async_reset();

`ifdef BURST_RR_ARBITER_LOCK_EN
        req  = 4'b0011;
        ack  = 1'b0;
        cycle();
        lock = 1'b1;
        ack  = 1'b1;
        repeat (10) cycle();
        chk("lock_cnt", 32'(bcnt), 4);
        chk("lock_gnt", 32'(gnt), 32'h1);
        lock = 1'b0;
        cycle();
        chk("unlock_gnt", 32'(gnt), 32'h2);
`endif

        // random traffic
        for (int i = 0; i < 800; i++) begin
            req   = N'($urandom);
            allow = ($urandom % 4) != 0;
            ack   = ($urandom % 3) != 0;
`ifdef BURST_RR_ARBITER_LOCK_EN
            lock  = ($urandom % 4) == 0;
`endif
            if ($urandom % 150 == 0) async_reset();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_rr_arbiter.md
Name: burst_rr_arbiter

Overview:
- Registered round-robin arbiter with a burst limit. Serves NumReq requesters and holds one owner for up to MaxBurst acknowledged beats before priority rotates.
- Successor to the combinational fixed-priority arbiter. Adds stored rotating priority, a one-hot registered grant, a granted index, beat counting and back-to-back re-arbitration.
- Sits in front of shared buses and memory ports in the common arbiter library.

Parameters:
- NumReq, 4, number of requesters (>=1).
- MaxBurst, 4, maximum acknowledged beats per ownership (>=1).
- IdxW, $clog2(NumReq) with minimum 1, width of index outputs (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- allow_req_i  input  1  permits selection of a new owner; does not affect an ongoing burst.
- req_i  input  NumReq  request per requester, level-sensitive.
- ack_i  input  1  beat consumed by downstream for the current owner.
- gnt_o  output  NumReq  one-hot registered grant; all zeros when idle.
- gnt_idx_o  output  IdxW  index of the current owner; 0 when idle.
- gnt_valid_o  output  1  an owner exists (equals |gnt_o).
- beat_cnt_o  output  $clog2(MaxBurst+1)  beats acknowledged in the current ownership.

Behaviour:
- Reset (arst_ni low, asynchronous): busy=0, gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, beat_cnt_o=0, ptr=0. Reset mid-burst drops the grant immediately.
- States: IDLE (no owner) and OWN (owner held).
- Selection function: first i with req_i[i]=1, scanning circularly from ptr, then ptr+1, ... mod NumReq.
- IDLE -> OWN:
  - Condition: allow_req_i=1 and |req_i.
  - Next edge: owner = selected index, gnt_o = onehot(owner), beat_cnt = 0.
  - Latency: 1 cycle from req to grant.
- A beat counts only when all hold in the same cycle: OWN, ack_i=1 and req_i[owner]=1. ack_i in IDLE, or while the owner's req is low, is ignored.
- In OWN, release occurs when either condition holds:
  - (a) req_i[owner]=0;
  - (b) a counted beat brings the count to MaxBurst.
- On release:
  - ptr <= (owner+1) mod NumReq.
  - If allow_req_i=1 and any other request is pending (selection from the new ptr), the new owner is granted at the same edge. Back-to-back transfer, no idle cycle.
  - Otherwise the block goes to IDLE.
- Simultaneous last-beat ack and owner request drop: a single release, ptr advances once.
- The released owner may be re-selected at release only if it is the sole requester. It is scanned last.
- allow_req_i=0 in OWN: the burst continues to its limit. On release the block goes to IDLE.
- Grant never changes without a release. gnt_o is always one-hot or zero.
- NumReq=1: ptr stays 0. The sole requester is re-granted after each MaxBurst beats, with no idle cycle if still requesting.
- Count width: $clog2(MaxBurst+1). The count resets to 0 on every new ownership and never exceeds MaxBurst.

Optional Feature:
- Macro: BURST_RR_ARBITER_LOCK_EN.
- When defined:
  - Adds input lock_i (1 bit).
  - While in OWN with lock_i=1, release condition (b) is suppressed. The beat count saturates at MaxBurst and the owner keeps the grant until its request drops.
  - Release then proceeds normally.
- When undefined: no lock_i port, and the burst limit is always enforced.

Decomposition:
- Package burst_rr_arbiter_pkg holds:
  - the state enum typedef (ARB_IDLE, ARB_OWN);
  - a function returning onehot(index, NumReq) for generic use.
- One combinational sub-module, rr_priority_pick:
  - Inputs: req vector and ptr.
  - Outputs: found flag and index.
  - Implementation: double-width masked priority scan.
  - Instantiated once for the normal pick and once for the release pick (ptr = owner+1).

Test Plan:
- Reset/idle: arst_ni low with req_i=4'b1111 -> all outputs 0. Release reset, allow_req_i=1 -> next cycle gnt_o=4'b0001, gnt_idx_o=0.
- Burst limit: req_i=4'b0101 held, ack_i=1 every cycle, MaxBurst=4 -> req 0 is granted for 4 beats, then the same edge grants 4'b0100 with no gap, then back to 4'b0001.
- Early release: owner 2 drops its request after 2 beats, req_i=4'b1000 pending -> gnt_o=4'b1000 next edge, ptr=3, beat_cnt_o=0.
- Ignored ack: ack_i=1 while idle, and while the owner's req is low -> beat_cnt_o unchanged, no spurious release.
- allow_req_i=0: mid-burst, owner 1 completes 4 beats -> goes IDLE. allow_req_i=1 with req_i=4'b0011 -> grants 4'b0001, because ptr=2 wraps to 0.
- Lock (macro defined): lock_i=1 and owner 0 acks for 10 cycles -> grant is held and beat_cnt_o saturates at 4. Lock dropped -> release on the next counted beat.
